// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
// State encodings are fixed so the controller's state register is easy to decode.

package serial_add_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // The counter must be able to hold the value WIDTH, so it gets one extra bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/Halfadder.sv
// Half adder used as the basic cell of the serial adder datapath.
// It is purely combinational.

module Halfadder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;

endmodule

// File: rtl/serial_fa_bit.sv
// 1-bit full adder built from two half adders plus an OR gate.
// It is purely combinational.

module serial_fa_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  logic s1;
  logic c1;
  logic c2;

  Halfadder u_ha1 (
    .a_i (a_i),
    .b_i (b_i),
    .s_o (s1),
    .c_o (c1)
  );

  Halfadder u_ha2 (
    .a_i (s1),
    .b_i (c_i),
    .s_o (s_o),
    .c_o (c2)
  );

  assign c_o = c1 | c2;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit unsigned adder: one full-adder cell, LSB first, WIDTH+1 cycle latency.
// Define SERIAL_ADD_OVF_EN to drive ovf with the signed-overflow flag; otherwise ovf is tied low.

module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  logic             fa_sum;
  logic             fa_cout;
  logic             last_bit;
  logic [WIDTH-1:0] sum_shift;

  assign last_bit = (cnt_q == LastBit);

  serial_fa_bit u_fa (
    .a_i (a_sh_q[0]),
    .b_i (b_sh_q[0]),
    .c_i (carry_q),
    .s_o (fa_sum),
    .c_o (fa_cout)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 lands at the LSB.
  if (WIDTH == 1) begin : g_shift_w1
    assign sum_shift = fa_sum;
  end else begin : g_shift_wn
    assign sum_shift = {fa_sum, sum_sh_q[WIDTH-1:1]};
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last_bit) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ready = (state_q == StIdle);
    done  = (state_q == StDone);
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          sum_sh_d = '0;
          carry_d  = 1'b0;
          cnt_d    = '0;
        end
      end
      StRun: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = sum_shift;
        carry_d  = fa_cout;
        cnt_d    = cnt_q + CntW'(1);
        if (last_bit) begin
          sum_d  = sum_shift;
          cout_d = fa_cout;
`ifdef SERIAL_ADD_OVF_EN
          // carry_q here is the carry into the MSB.
          ovf_d  = carry_q ^ fa_cout;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=8 with hand-computed directed vectors.
// Expected ovf follows SERIAL_ADD_OVF_EN, which must match the DUT build.

module tb_serial_add_ctrl;

  localparam int unsigned W = 8;
`ifdef SERIAL_ADD_OVF_EN
  localparam bit OvfEn = 1'b1;
`else
  localparam bit OvfEn = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int cyc = 0;
  int last_done_cyc = -1;
  bit hold_phase = 1'b0;
  exp_t sb[$];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .ready (ready),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    if (!hold_phase) last_done_cyc = -1;
    if (done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sum", 32'(sum), 32'(e.s));
        chk("cout", 32'(cout), 32'(e.c));
        chk("ovf", 32'(ovf), 32'(e.o));
      end
      if (hold_phase && last_done_cyc >= 0) chk("done_period", 32'(cyc - last_done_cyc), 32'd10);
      last_done_cyc = cyc;
    end
  end

  function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic o);
    exp_t e;
    e.s = s;
    e.c = c;
    e.o = o & OvfEn;
    return e;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", 32'(ready), 32'd1);
  endtask

  // One add with latency and handshake checks; result itself is checked by the monitor.
  task automatic do_add(input logic [W-1:0] x, input logic [W-1:0] y, input exp_t e);
    int n = 0;
    bit seen = 1'b0;
    @(negedge clk);
    wait_ready();
    a = x;
    b = y;
    start = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    chk("ready_low_after_accept", 32'(ready), 32'd0);
    while (!seen && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (done === 1'b1) seen = 1'b1;
    end
    chk("done_latency_edges", 32'(n), 32'(W));
    @(posedge clk);
    #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("ready_after_done", 32'(ready), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int d0;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;

    do_add(8'h00, 8'h00, mk(8'h00, 1'b0, 1'b0));
    do_add(8'hFF, 8'h01, mk(8'h00, 1'b1, 1'b0));
    do_add(8'h7F, 8'h01, mk(8'h80, 1'b0, 1'b1));
    drain();

    // Start pulsed mid-RUN with different operands must be ignored.
    d0 = done_cnt;
    @(negedge clk);
    a = 8'hA5;
    b = 8'h5A;
    start = 1'b1;
    sb.push_back(mk(8'hFF, 1'b0, 1'b0));
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'h11;
    b = 8'h22;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (15) @(negedge clk);
    chk("single_done_ignored_start", 32'(done_cnt - d0), 32'd1);

    // Start held high: back-to-back accepts every WIDTH+2 cycles.
    d0 = done_cnt;
    @(negedge clk);
    hold_phase = 1'b1;
    a = 8'h80;
    b = 8'h80;
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (ready === 1'b1) sb.push_back(mk(8'h00, 1'b1, 1'b1));
      @(negedge clk);
    end
    start = 1'b0;
    drain();
    hold_phase = 1'b0;
    chk("held_start_done_count", 32'(done_cnt - d0), 32'd3);

    // Reset while RUN is about to process bit 4.
    d0 = done_cnt;
    @(negedge clk);
    a = 8'h0F;
    b = 8'h01;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    repeat (15) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);

    do_add(8'h03, 8'h04, mk(8'h07, 1'b0, 1'b0));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
